// File: rtl/synth_pkg.sv
// Shared definitions for the polyphonic tone generator.
// Provides the note period table, the default counter width and the
// ASCII key to half-period lookup used at trigger time.
package synth_pkg;

  localparam int unsigned CNT_W_DEFAULT = 19;

  localparam int unsigned P_A = 191110;
  localparam int unsigned P_W = 180388;
  localparam int unsigned P_S = 170265;
  localparam int unsigned P_E = 160705;
  localparam int unsigned P_D = 151685;
  localparam int unsigned P_F = 143172;
  localparam int unsigned P_T = 135138;
  localparam int unsigned P_G = 127551;
  localparam int unsigned P_Y = 120395;
  localparam int unsigned P_H = 113636;
  localparam int unsigned P_U = 107259;
  localparam int unsigned P_J = 101239;
  localparam int unsigned P_K = 95557;

  typedef struct packed {
    logic                     valid;
    logic [CNT_W_DEFAULT-1:0] period;
  } key_lut_t;

  // Unknown codes come back with valid=0 so the caller can ignore them.
  function automatic key_lut_t key_to_period(input logic [7:0] code);
    key_lut_t r;
    r.valid  = 1'b1;
    r.period = '0;
    case (code)
      8'h61:   r.period = CNT_W_DEFAULT'(P_A);
      8'h77:   r.period = CNT_W_DEFAULT'(P_W);
      8'h73:   r.period = CNT_W_DEFAULT'(P_S);
      8'h65:   r.period = CNT_W_DEFAULT'(P_E);
      8'h64:   r.period = CNT_W_DEFAULT'(P_D);
      8'h66:   r.period = CNT_W_DEFAULT'(P_F);
      8'h74:   r.period = CNT_W_DEFAULT'(P_T);
      8'h67:   r.period = CNT_W_DEFAULT'(P_G);
      8'h79:   r.period = CNT_W_DEFAULT'(P_Y);
      8'h68:   r.period = CNT_W_DEFAULT'(P_H);
      8'h75:   r.period = CNT_W_DEFAULT'(P_U);
      8'h6A:   r.period = CNT_W_DEFAULT'(P_J);
      8'h6B:   r.period = CNT_W_DEFAULT'(P_K);
      default: r.valid  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice with a fixed sounding time.
// Ports: clk/rst, load_i/load_key_i/load_period_i start or retrigger the
// voice; active_o, wave_o (square wave) and key_o report its state.
module tone_voice #(
  parameter int unsigned CNT_W       = 19,
  parameter int unsigned HOLD_CYCLES = 12_500_000,
  parameter int unsigned HOLD_W      = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [7:0]       load_key_i,
  input  logic [CNT_W-1:0] load_period_i,
  output logic             active_o,
  output logic             wave_o,
  output logic [7:0]       key_o
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic              active_q, active_d;
  logic              wave_q,   wave_d;
  logic [7:0]        key_q,    key_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;

  // Load has priority over release, so a retrigger on the last hold cycle keeps the voice alive.
  always_comb begin
    active_d = active_q;
    wave_d   = wave_q;
    key_d    = key_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    if (load_i) begin
      active_d = 1'b1;
      wave_d   = 1'b0;
      key_d    = load_key_i;
      period_d = load_period_i;
      cnt_d    = '0;
      hold_d   = '0;
    end else if (active_q) begin
      if (hold_q == HOLD_LAST) begin
        active_d = 1'b0;
        wave_d   = 1'b0;
        cnt_d    = '0;
        hold_d   = '0;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
        if (cnt_q == period_q) begin
          cnt_d  = '0;
          wave_d = ~wave_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      wave_q   <= 1'b0;
      key_q    <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      active_q <= active_d;
      wave_q   <= wave_d;
      key_q    <= key_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  assign active_o = active_q;
  assign wave_o   = wave_q;
  assign key_o    = key_q;

endmodule

// File: rtl/poly_tonegen.sv
// Polyphonic keyboard tone generator.
// Ports: clk/rst; data (ASCII key), data_valid (rising edge = keypress),
// octave (period right shift); mix_out (count of high voices),
// active_mask (sounding voices), signal (1-bit sigma-delta speaker drive).
module poly_tonegen
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned HOLD_CYCLES = 12_500_000,
  parameter int unsigned HOLD_W      = 25,
  parameter int unsigned MIX_W       = $clog2(NUM_VOICES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data,
  input  logic                  data_valid,
  input  logic [1:0]            octave,
  output logic [MIX_W-1:0]      mix_out,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic                  signal
);

  localparam int unsigned PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned ACC_W = MIX_W + 1;

  logic                  prev_dv_q;
  logic [PTR_W-1:0]      steal_ptr_q, steal_ptr_d;
  logic [MIX_W-1:0]      mix_q, mix_d;
  logic [ACC_W-1:0]      acc_q, acc_d, sum_c;
  logic                  sig_q, sig_d;
  logic [NUM_VOICES-1:0] mask_q;

  key_lut_t              lut_c;
  logic                  trig_c;
  logic [CNT_W-1:0]      load_period_c;
  logic [NUM_VOICES-1:0] load_c;
  logic [NUM_VOICES-1:0] v_active;
  logic [NUM_VOICES-1:0] v_wave;
  logic [7:0]            v_key [NUM_VOICES];
  logic                  hit_found, free_found;
  logic [PTR_W-1:0]      hit_idx, free_idx;

  assign lut_c         = key_to_period(data);
  assign trig_c        = data_valid & ~prev_dv_q & lut_c.valid & ~rst;
  assign load_period_c = CNT_W'(lut_c.period >> octave);

  // Voice allocation: retrigger same key, else lowest free voice, else round-robin steal.
  always_comb begin
    load_c      = '0;
    steal_ptr_d = steal_ptr_q;
    hit_found   = 1'b0;
    free_found  = 1'b0;
    hit_idx     = '0;
    free_idx    = '0;
    // Descending scan so the lowest index is the one left standing.
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (v_active[i] && (v_key[i] == data)) begin
        hit_found = 1'b1;
        hit_idx   = PTR_W'(i);
      end
      if (!v_active[i]) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(i);
      end
    end
    if (trig_c) begin
      if (hit_found) begin
        load_c[hit_idx] = 1'b1;
      end else if (free_found) begin
        load_c[free_idx] = 1'b1;
      end else begin
        load_c[steal_ptr_q] = 1'b1;
        steal_ptr_d = (steal_ptr_q == PTR_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + PTR_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    tone_voice #(
      .CNT_W       (CNT_W),
      .HOLD_CYCLES (HOLD_CYCLES),
      .HOLD_W      (HOLD_W)
    ) u_voice (
      .clk           (clk),
      .rst           (rst),
      .load_i        (load_c[g]),
      .load_key_i    (data),
      .load_period_i (load_period_c),
      .active_o      (v_active[g]),
      .wave_o        (v_wave[g]),
      .key_o         (v_key[g])
    );
  end

  // Mixer popcount and first-order sigma-delta on the registered mix.
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      mix_d = mix_d + MIX_W'(v_active[i] & v_wave[i]);
    end
    sum_c = acc_q + ACC_W'(mix_q);
    if (sum_c >= ACC_W'(NUM_VOICES)) begin
      sig_d = 1'b1;
      acc_d = sum_c - ACC_W'(NUM_VOICES);
    end else begin
      sig_d = 1'b0;
      acc_d = sum_c;
    end
  end

  // prev_dv tracks data_valid through reset so a held level is never an event.
  always_ff @(posedge clk) begin
    prev_dv_q <= data_valid;
    if (rst) begin
      steal_ptr_q <= '0;
      mix_q       <= '0;
      acc_q       <= '0;
      sig_q       <= 1'b0;
      mask_q      <= '0;
    end else begin
      steal_ptr_q <= steal_ptr_d;
      mix_q       <= mix_d;
      acc_q       <= acc_d;
      sig_q       <= sig_d;
      mask_q      <= v_active;
    end
  end

  assign mix_out     = mix_q;
  assign active_mask = mask_q;
  assign signal      = sig_q;

endmodule

// File: tb/tb_poly_tonegen.sv
// Directed self-checking bench for poly_tonegen.
// dut_a uses a short hold (1000) for allocation/retrigger/reset checks;
// dut_b uses a long hold (50000) so waveforms toggle and the mix reaches 4.
module tb_poly_tonegen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       dv, dv_b;
  logic [1:0] octave;
  logic [2:0] mix_a, mix_b;
  logic [3:0] mask_a, mask_b;
  logic       sig_a, sig_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_load = 0;
  int la, l0, l1, l2, lj;
  int ld [6];
  logic       prev_s;
  logic [7:0] k2 [6]    = '{8'h61, 8'h73, 8'h64, 8'h66, 8'h67, 8'h68};
  logic [3:0] exp_m [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};

  poly_tonegen #(.HOLD_CYCLES(1000)) dut_a (
    .clk(clk), .rst(rst), .data(data), .data_valid(dv), .octave(octave),
    .mix_out(mix_a), .active_mask(mask_a), .signal(sig_a)
  );

  poly_tonegen #(.HOLD_CYCLES(50000)) dut_b (
    .clk(clk), .rst(rst), .data(data), .data_valid(dv_b), .octave(octave),
    .mix_out(mix_b), .active_mask(mask_b), .signal(sig_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // which: 0 -> dut_a, 1 -> dut_b, 2 -> both
  task automatic press(input logic [7:0] k, input int which);
    data = k;
    if (which != 1) dv = 1'b1;
    if (which != 0) dv_b = 1'b1;
    tick();
    last_load = cyc;
    dv = 1'b0;
    dv_b = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; data = 8'h00; dv = 1'b0; dv_b = 1'b0; octave = 2'd3;
    tick(); tick();
    chk("rst_mask_a", 32'(mask_a), 32'h0);
    chk("rst_mix_a",  32'(mix_a),  32'h0);
    chk("rst_sig_a",  32'(sig_a),  32'h0);
    chk("rst_mask_b", 32'(mask_b), 32'h0);
    rst = 1'b0;
    tick();

    // 1: single key, load latency, first toggle after period+1 cycles
    data = 8'h61; dv = 1'b1; dv_b = 1'b1;
    tick();
    la = cyc;
    chk("t1_mask_at_load_edge", 32'(mask_a), 32'h0);
    dv = 1'b0; dv_b = 1'b0;
    tick();
    chk("t1_mask_a", 32'(mask_a), 32'h1);
    chk("t1_mask_b", 32'(mask_b), 32'h1);
    wait_until(la + 1000);
    chk("t1_hold_last", 32'(mask_a), 32'h1);
    tick();
    chk("t1_released", 32'(mask_a), 32'h0);
    wait_until(la + 23889);
    chk("t1_mix_before_toggle", 32'(mix_b), 32'h0);
    tick();
    chk("t1_mix_after_toggle", 32'(mix_b), 32'h1);
    chk("t1_mix_a_silent", 32'(mix_a), 32'h0);

    // 3: retrigger same key at 900 cycles
    press(8'h61, 0);
    l1 = last_load;
    chk("t3_first_load", 32'(mask_a), 32'h1);
    wait_until(l1 + 899);
    press(8'h61, 0);
    l2 = last_load;
    chk("t3_no_second_voice", 32'(mask_a), 32'h1);
    wait_until(l1 + 1001);
    chk("t3_kept_alive", 32'(mask_a), 32'h1);
    wait_until(l2 + 1000);
    chk("t3_hold_last", 32'(mask_a), 32'h1);
    wait_until(l2 + 1001);
    chk("t3_released", 32'(mask_a), 32'h0);

    // 4: held level gives one event; unknown key ignored
    data = 8'h6A; dv = 1'b1;
    tick();
    lj = cyc;
    repeat (49) tick();
    dv = 1'b0;
    tick();
    data = 8'h7A; dv = 1'b1;
    repeat (50) tick();
    dv = 1'b0;
    tick();
    chk("t4_z_ignored", 32'(mask_a), 32'h1);
    wait_until(lj + 1000);
    chk("t4_hold_last", 32'(mask_a), 32'h1);
    wait_until(lj + 1001);
    chk("t4_single_event", 32'(mask_a), 32'h0);

    // 2: fill all voices, then steal voice0 and voice1
    for (int i = 0; i < 6; i++) begin
      press(k2[i], 0);
      ld[i] = last_load;
      chk($sformatf("t2_fill%0d", i), 32'(mask_a), 32'(exp_m[i]));
    end
    wait_until(ld[2] + 1000);
    chk("t2_all_on", 32'(mask_a), 32'hF);
    wait_until(ld[2] + 1001);
    chk("t2_v2_off", 32'(mask_a), 32'hB);
    wait_until(ld[3] + 1001);
    chk("t2_v3_off", 32'(mask_a), 32'h3);
    wait_until(ld[4] + 1001);
    chk("t2_v0_stolen_off", 32'(mask_a), 32'h2);
    wait_until(ld[5] + 1001);
    chk("t2_v1_stolen_off", 32'(mask_a), 32'h0);

    // 5: sigma-delta at mix 4 and mix 2 (dut_b)
    press(8'h61, 1);
    l0 = last_load;
    chk("t5_retrig_b", 32'(mask_b), 32'h1);
    press(8'h73, 1);
    press(8'h64, 1);
    press(8'h66, 1);
    chk("t5_mask_full", 32'(mask_b), 32'hF);
    wait_until(l0 + 23889);
    chk("t5_mix3", 32'(mix_b), 32'h3);
    tick();
    chk("t5_mix4", 32'(mix_b), 32'h4);
    wait_until(l0 + 29999);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_mix4_hold", 32'(mix_b), 32'h4);
      chk("t5_sig_const1", 32'(sig_b), 32'h1);
    end
    wait_until(l0 + 40000);
    prev_s = sig_b;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_mix2", 32'(mix_b), 32'h2);
      chk("t5_sig_alternate", 32'(prev_s) + 32'(sig_b), 32'h1);
      prev_s = sig_b;
    end

    // 6: reset mid-note with a coincident edge
    press(8'h61, 0);
    press(8'h73, 0);
    press(8'h64, 0);
    chk("t6_three_on", 32'(mask_a), 32'h7);
    rst = 1'b1; data = 8'h66; dv = 1'b1;
    tick();
    chk("t6_mask_a", 32'(mask_a), 32'h0);
    chk("t6_mix_a",  32'(mix_a),  32'h0);
    chk("t6_sig_a",  32'(sig_a),  32'h0);
    chk("t6_mask_b", 32'(mask_b), 32'h0);
    chk("t6_mix_b",  32'(mix_b),  32'h0);
    chk("t6_sig_b",  32'(sig_b),  32'h0);
    rst = 1'b0;
    tick(); tick();
    chk("t6_no_load", 32'(mask_a), 32'h0);
    dv = 1'b0;
    tick();
    press(8'h66, 0);
    chk("t6_after_rst_load", 32'(mask_a), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_tonegen.md
Name: poly_tonegen

Overview:
Polyphonic successor to the single-voice keyboard tone generator. Each rising edge of data_valid carries an ASCII key code. Valid note keys go to one of NUM_VOICES square-wave voices; the voice releases after HOLD_CYCLES. Voices are summed into a multi-bit mix and a 1-bit first-order sigma-delta output that drives the speaker pin.

Parameters:
NUM_VOICES, 4, simultaneous voices (>=1)
CNT_W, 19, width of period counters; must hold the largest table period
HOLD_CYCLES, 12_500_000, cycles a voice sounds after trigger
HOLD_W, 25, width of hold counter; must hold HOLD_CYCLES-1
MIX_W, $clog2(NUM_VOICES+1), width of mix_out

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
data  in  8  ASCII key code, valid when data_valid rises
data_valid  in  1  level strobe; only the rising edge is an event
octave  in  2  sampled at trigger; voice period = table period >> octave
mix_out  out  MIX_W  count of voices whose waveform is high
active_mask  out  NUM_VOICES  bit i = voice i sounding
signal  out  1  sigma-delta bitstream, density = mix_out/NUM_VOICES

Behaviour:
- Single clock, synchronous active-high reset. Reset values: all voices inactive, counters 0, waveforms 0, steal_ptr 0, sigma-delta accumulator 0, mix_out 0, active_mask 0, signal 0.
- Edge detect: prev_dv <= data_valid every cycle, including during rst. Event = data_valid && !prev_dv. A level held high across reset release is not an event.
- Key table (synth_pkg): a=191110, w=180388, s=170265, e=160705, d=151685, f=143172, t=135138, g=127551, y=120395, h=113636, u=107259, j=101239, k=95557.
- Unknown codes are ignored: no allocation and no state change. This differs from the old default-to-C behaviour.
- Allocation when an event occurs in cycle t (voice state updates at t+1), in priority order:
  (1) An active voice holding the same key code is retriggered.
  (2) Otherwise the lowest-index inactive voice is used.
  (3) Otherwise the voice at steal_ptr is stolen, and steal_ptr increments modulo NUM_VOICES.
- Loading a voice sets key, period = table>>octave, counter 0, waveform 0, hold 0, active 1.
- Voice run, each cycle while active:
  - If counter == period: counter 0 and toggle waveform. Otherwise counter+1.
  - Half-period is therefore period+1 cycles.
  - hold+1 each cycle. When hold == HOLD_CYCLES-1 the voice goes inactive next cycle, with waveform and counter cleared.
- Simultaneous release and retrigger/allocation of the same voice: the trigger wins and the voice stays active.
- Inactive voices contribute 0 and hold counter/waveform at 0.
- mix_out is registered: popcount(active & waveform), 1 cycle after the voice state.
- Sigma-delta, registered, using mix_out:
  - s = acc + mix_out.
  - If s >= NUM_VOICES: signal=1 and acc = s - NUM_VOICES. Otherwise signal=0 and acc = s.
  - acc width MIX_W+1, no overflow.
- active_mask is registered and equals each voice's active flag.
- rst asserted mid-note: all outputs return to reset values on the next edge. Any event in that cycle is dropped.

Decomposition:
- synth_pkg: the 13 note period localparams, function key_to_period(byte) returning period plus a valid flag, and the CNT_W default.
- Sub-module tone_voice, one per voice via generate.
  - Inputs: clk, rst, load, load_key, load_period, octave-shifted period.
  - Outputs: active, waveform, key.
  - Internally holds the period counter and hold counter.
- The top level holds edge detect, allocation/steal pointer, mixer and sigma-delta.

Test Plan:
1. Bench settings: HOLD_CYCLES=1000, octave=3. Stimulus: rst, then rising edge with data=0x61 ('a').
   Required: active_mask=0001 one cycle later; voice0 period 23888; waveform first goes high 23889 cycles after load. At HOLD_CYCLES=1000 this toggle is not reached before release, so rerun with HOLD_CYCLES=50000 to check it.
2. Stimulus: keys 'a','s','d','f','g' in sequence.
   Required: mask fills 0001→1111. The fifth key steals voice0 and steal_ptr becomes 1. A sixth key 'h' steals voice1.
3. Stimulus: retrigger 'a' at 900 cycles (HOLD=1000).
   Required: same voice reloads with counter 0 and stays active until 1000 cycles after the retrigger. No second voice is allocated.
4. Stimulus: data=0x7A ('z'), and data_valid held high for 50 cycles.
   Required: no allocation and mask unchanged. A held-high level yields exactly one event.
5. Stimulus: force all 4 voices high (mix_out=4), then 2 voices high.
   Required: signal constant 1 for mix 4; signal alternates 1010 (density 1/2) for mix 2.
6. Stimulus: assert rst while 3 voices are sounding, with a simultaneous data_valid edge.
   Required: next cycle mask=0, mix_out=0, signal=0, and no voice loaded.
